// File: rtl/fb_window_writer.sv
// Framebuffer window write engine.
// Pixels are format-converted as they enter a small FIFO, then written to SRAM on
// sequencer-granted slots at the window cursor position. Off-screen pixels consume
// their slot but are dropped and counted. A frame fill drains the FIFO first, then
// writes the fill colour over the whole visible frame.
module fb_window_writer #(
   parameter int H_RES      = 480,
   parameter int V_RES      = 272,
   parameter int ROW_OFFSET = 0,
   parameter int CW         = 10,
   parameter int ADDR_W     = 18,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              pix_valid_i,
   input  logic [23:0]       pix_data_i,
   output logic              pix_ready_o,
   input  logic              fmt_mode_i,
   input  logic              win_load_i,
   input  logic [CW-1:0]     win_x0_i,
   input  logic [CW-1:0]     win_x1_i,
   input  logic [CW-1:0]     win_y0_i,
   input  logic [CW-1:0]     win_y1_i,
   output logic              win_ready_o,
   output logic              win_err_o,
   input  logic              fill_req_i,
   input  logic [23:0]       fill_color_i,
   output logic              fill_busy_o,
   output logic              fill_done_o,
   input  logic              wr_slot_i,
   output logic              sram_we_o,
   output logic [ADDR_W-1:0] sram_waddr_o,
   output logic [23:0]       sram_wdata_o,
   output logic [15:0]       clip_cnt_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_FILL  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int NPIX = H_RES * V_RES;
   localparam int FA_W = (NPIX > 1) ? $clog2(NPIX) : 1;

   localparam logic [FA_W-1:0] FILL_LAST = FA_W'(NPIX - 1);
   localparam logic [31:0]     H_RES_U   = 32'(H_RES);
   localparam logic [31:0]     V_RES_U   = 32'(V_RES);
   localparam logic [31:0]     ROW_OFF_U = 32'(ROW_OFFSET);
   localparam logic [31:0]     ROW_BASE  = 32'(ROW_OFFSET * H_RES);

   // FIFO storage and pointers (one extra pointer bit separates full from empty)
   logic [23:0]       mem_q [FIFO_DEPTH];
   logic [PW:0]       wptr_q;
   logic [PW:0]       rptr_q;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              pop_pix;
   logic [23:0]       push_word;

   // Window and cursor
   logic [CW-1:0]     x0_q, x1_q, y0_q, y1_q;
   logic [CW-1:0]     cx_q, cy_q, cx_d, cy_d;
   logic              win_bad;
   logic              win_accept;
   logic              on_screen;
   logic [ADDR_W-1:0] pix_addr;

   // Fill sequencing
   logic [1:0]        state_q, state_d;
   logic [FA_W-1:0]   fill_addr_q, fill_addr_d;
   logic [23:0]       fill_color_q;
   logic              fill_wr;
   logic [ADDR_W-1:0] fill_waddr;

   // Registered outputs
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [23:0]       wdata_q;
   logic [15:0]       clip_q;
   logic              err_q;
   logic              done_q;

   assign fifo_empty  = (wptr_q == rptr_q);
   assign fifo_full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign fill_busy_o = (state_q != S_IDLE);
   assign pix_ready_o = !fifo_full && !fill_busy_o;
   assign win_ready_o = fifo_empty && !fill_busy_o;
   assign push        = pix_valid_i && pix_ready_o;
   // Pushing is blocked while a fill runs, so the FIFO is empty in FILL/DONE.
   assign pop_pix     = wr_slot_i && !fifo_empty;
   assign fill_wr     = wr_slot_i && (state_q == S_FILL);

   assign win_bad     = (win_x1_i < win_x0_i) || (win_y1_i < win_y0_i);
   assign win_accept  = win_load_i && win_ready_o;
   assign on_screen   = (32'(cx_q) < H_RES_U) && (32'(cy_q) < V_RES_U);
   assign pix_addr    = ADDR_W'((32'(cy_q) + ROW_OFF_U) * H_RES_U + 32'(cx_q));
   assign fill_waddr  = ADDR_W'(32'(fill_addr_q) + ROW_BASE);

   assign sram_we_o    = we_q;
   assign sram_waddr_o = waddr_q;
   assign sram_wdata_o = wdata_q;
   assign clip_cnt_o   = clip_q;
   assign win_err_o    = err_q;
   assign fill_done_o  = done_q;

   // Convert the incoming pixel to the {B8,G8,R8} SRAM word, replicating MSBs for 565
   always_comb begin
      if (fmt_mode_i) begin
         push_word = {pix_data_i[7:0], pix_data_i[15:8], pix_data_i[23:16]};
      end else begin
         push_word = {pix_data_i[4:0],   pix_data_i[4:2],
                      pix_data_i[10:5],  pix_data_i[10:9],
                      pix_data_i[15:11], pix_data_i[15:13]};
      end
   end

   // FIFO storage write; contents need no reset because the pointers define validity
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q[PW-1:0]] <= push_word;
      end
   end

   // FIFO pointer update
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push)    wptr_q <= wptr_q + 1'b1;
         if (pop_pix) rptr_q <= rptr_q + 1'b1;
      end
   end

   // Cursor next state: a window load restarts it, a pixel pop advances it with wrap
   always_comb begin
      cx_d = cx_q;
      cy_d = cy_q;
      if (win_accept && !win_bad) begin
         cx_d = win_x0_i;
         cy_d = win_y0_i;
      end else if (pop_pix) begin
         if (cx_q == x1_q) begin
            cx_d = x0_q;
            cy_d = (cy_q == y1_q) ? y0_q : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
      end
   end

   // Window bounds, cursor and the window-rejected pulse
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x0_q  <= '0;
         x1_q  <= CW'(H_RES - 1);
         y0_q  <= '0;
         y1_q  <= CW'(V_RES - 1);
         cx_q  <= '0;
         cy_q  <= '0;
         err_q <= 1'b0;
      end else begin
         if (win_accept && !win_bad) begin
            x0_q <= win_x0_i;
            x1_q <= win_x1_i;
            y0_q <= win_y0_i;
            y1_q <= win_y1_i;
         end
         cx_q  <= cx_d;
         cy_q  <= cy_d;
         err_q <= win_accept && win_bad;
      end
   end

   // Fill FSM next state: drain queued pixels, sweep the frame, then signal done
   always_comb begin
      state_d     = state_q;
      fill_addr_d = fill_addr_q;
      case (state_q)
         S_IDLE: begin
            if (fill_req_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_empty) begin
               state_d     = S_FILL;
               fill_addr_d = '0;
            end
         end
         S_FILL: begin
            if (wr_slot_i) begin
               if (fill_addr_q == FILL_LAST) state_d = S_DONE;
               else                          fill_addr_d = fill_addr_q + FA_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Fill FSM registers; the colour is captured only when a request is accepted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         fill_addr_q  <= '0;
         fill_color_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         if (state_q == S_IDLE && fill_req_i) fill_color_q <= fill_color_i;
         // Done pulses one cycle after the final fill write strobe.
         done_q <= (state_q == S_DONE);
      end
   end

   // SRAM write port: registered one cycle after the granted slot
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= fill_wr || (pop_pix && on_screen);
         if (fill_wr) begin
            waddr_q <= fill_waddr;
            wdata_q <= fill_color_q;
         end else if (pop_pix && on_screen) begin
            waddr_q <= pix_addr;
            wdata_q <= mem_q[rptr_q[PW-1:0]];
         end
      end
   end

   // Saturating count of pixels dropped for falling outside the screen
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clip_q <= '0;
      end else if (pop_pix && !on_screen && clip_q != 16'hFFFF) begin
         clip_q <= clip_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_fb_window_writer.sv
// Bench for fb_window_writer: directed and randomized pixel streams, window loads,
// clipping, back-pressure, frame fill and resets. Expected SRAM writes are queued
// by a pixel-level model at push time and consumed by an independent write monitor.
module tb_fb_window_writer;

   localparam int H    = 480;
   localparam int V    = 8;
   localparam int RO   = 1;
   localparam int CW   = 10;
   localparam int AW   = 18;
   localparam int FD   = 8;
   localparam int NPIX = H * V;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pix_valid, fmt_mode, win_load, fill_req, wr_slot;
   logic [23:0]   pix_data, fill_color;
   logic [CW-1:0] win_x0, win_x1, win_y0, win_y1;
   logic          pix_ready_o, win_ready_o, win_err_o, fill_busy_o, fill_done_o, sram_we_o;
   logic [AW-1:0] sram_waddr_o;
   logic [23:0]   sram_wdata_o;
   logic [15:0]   clip_cnt_o;

   always #5 clk = ~clk;

   fb_window_writer #(
      .H_RES(H), .V_RES(V), .ROW_OFFSET(RO), .CW(CW), .ADDR_W(AW), .FIFO_DEPTH(FD)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pix_ready_o),
      .fmt_mode_i(fmt_mode),
      .win_load_i(win_load), .win_x0_i(win_x0), .win_x1_i(win_x1),
      .win_y0_i(win_y0), .win_y1_i(win_y1),
      .win_ready_o(win_ready_o), .win_err_o(win_err_o),
      .fill_req_i(fill_req), .fill_color_i(fill_color),
      .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
      .wr_slot_i(wr_slot),
      .sram_we_o(sram_we_o), .sram_waddr_o(sram_waddr_o), .sram_wdata_o(sram_wdata_o),
      .clip_cnt_o(clip_cnt_o)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [23:0]   d;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   int  wr_count = 0;
   int  last_we_cyc = 0;
   int  slot_mode = 0;     // 0 off, 1 random, 2 every 4th cycle
   int  slot_pct = 60;
   bit  fill_armed = 0;
   bit  done_seen = 0;
   bit  ready_leak = 0;

   // Reference model state: window, cursor, clip count
   int m_x0, m_x1, m_y0, m_y1, m_cx, m_cy, m_clip;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [23:0] conv(input logic mode, input logic [23:0] d);
      int r, g, b;
      if (mode) begin
         r = int'(d[23:16]); g = int'(d[15:8]); b = int'(d[7:0]);
      end else begin
         r = int'(d[15:11]); g = int'(d[10:5]); b = int'(d[4:0]);
         r = r * 8 + r / 4;
         g = g * 4 + g / 16;
         b = b * 8 + b / 4;
      end
      return {8'(b), 8'(g), 8'(r)};
   endfunction

   task automatic model_reset();
      m_x0 = 0; m_x1 = H - 1; m_y0 = 0; m_y1 = V - 1;
      m_cx = 0; m_cy = 0; m_clip = 0;
      exp_q.delete();
   endtask

   // One accepted pixel: decide its screen position and queue the write it should cause
   task automatic model_push(input logic mode, input logic [23:0] d);
      wr_t e;
      if (m_cx < H && m_cy < V) begin
         e.a = AW'(((m_cy + RO) * H + m_cx) % (1 << AW));
         e.d = conv(mode, d);
         exp_q.push_back(e);
      end else if (m_clip < 65535) begin
         m_clip++;
      end
      if (m_cx == m_x1) begin
         m_cx = m_x0;
         m_cy = (m_cy == m_y1) ? m_y0 : m_cy + 1;
      end else begin
         m_cx++;
      end
   endtask

   // Write-slot generator
   initial begin
      wr_slot = 1'b0;
      forever begin
         @(negedge clk);
         case (slot_mode)
            0:       wr_slot = 1'b0;
            1:       wr_slot = ($urandom_range(0, 99) < slot_pct);
            default: wr_slot = (cyc % 4 == 0);
         endcase
      end
   end

   // Monitor: every write strobe is matched against the head of the expected queue
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst_n && sram_we_o) begin
            wr_count++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_write: got addr %0d data %06h expected no write", sram_waddr_o, sram_wdata_o);
            end else begin
               e = exp_q.pop_front();
               $display("wr %0d addr=%0d data=%06h", wr_count, sram_waddr_o, sram_wdata_o);
               check("waddr", 32'(sram_waddr_o), 32'(e.a));
               check("wdata", 32'(sram_wdata_o), 32'(e.d));
            end
         end
         if (rst_n && fill_done_o) begin
            check("fill_done_expected", 32'(fill_armed), 1);
            check("fill_done_latency", cyc, last_we_cyc + 1);
            check("fill_queue_empty", exp_q.size(), 0);
            check("fill_busy_at_done", 32'(fill_busy_o), 0);
            done_seen = 1;
         end else if (fill_armed && !done_seen && pix_ready_o) begin
            ready_leak = 1;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_pix_ready", 32'(pix_ready_o), 1);
      check("rst_win_ready", 32'(win_ready_o), 1);
      check("rst_sram_we", 32'(sram_we_o), 0);
      check("rst_waddr", 32'(sram_waddr_o), 0);
      check("rst_wdata", 32'(sram_wdata_o), 0);
      check("rst_clip", 32'(clip_cnt_o), 0);
      check("rst_fill_busy", 32'(fill_busy_o), 0);
      check("rst_fill_done", 32'(fill_done_o), 0);
      check("rst_win_err", 32'(win_err_o), 0);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      fill_armed = 0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_pix(input logic mode, input logic [23:0] d);
      int t = 0;
      @(negedge clk);
      pix_valid = 1'b1; pix_data = d; fmt_mode = mode;
      while (!pix_ready_o && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) begin
         check("push_timeout", 1, 0);
      end else begin
         model_push(mode, d);
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
   endtask

   task automatic load_win(input int x0, input int x1, input int y0, input int y1, output bit rdy);
      bit bad;
      @(negedge clk);
      win_load = 1'b1;
      win_x0 = CW'(x0); win_x1 = CW'(x1); win_y0 = CW'(y0); win_y1 = CW'(y1);
      rdy = win_ready_o;
      @(posedge clk);
      #1;
      win_load = 1'b0;
      bad = (x1 < x0) || (y1 < y0);
      if (rdy && !bad) begin
         m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1;
         m_cx = x0; m_cy = y0;
      end
      @(negedge clk);
      check("win_err", 32'(win_err_o), 32'(rdy && bad));
      @(negedge clk);
      check("win_err_pulse_end", 32'(win_err_o), 0);
   endtask

   task automatic drain();
      int t = 0;
      while (t < 20000 && !(win_ready_o && exp_q.size() == 0)) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) check("drain_timeout", 1, 0);
      repeat (2) @(negedge clk);
      check("clip_cnt", 32'(clip_cnt_o), 32'(m_clip));
   endtask

   task automatic do_fill(input logic [23:0] color, output bit acc);
      wr_t e;
      bit  busy;
      @(negedge clk);
      fill_req = 1'b1; fill_color = color;
      busy = fill_busy_o;
      @(posedge clk);
      #1;
      fill_req = 1'b0;
      acc = !busy;
      if (acc) begin
         for (int i = 0; i < NPIX; i++) begin
            e.a = AW'((i + RO * H) % (1 << AW));
            e.d = color;
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
      check("fill_busy_after_req", 32'(fill_busy_o), 1);
      if (acc) begin
         done_seen = 0; ready_leak = 0; fill_armed = 1;
      end
   endtask

   task automatic wait_fill_done();
      int t = 0;
      while (!done_seen && t < 30000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 30000) check("fill_done_timeout", 1, 0);
      check("pix_ready_low_during_fill", 32'(ready_leak), 0);
      fill_armed = 0;
   endtask

   initial begin
      bit rdy, acc;
      int w0;
      rst_n = 1'b0; pix_valid = 0; pix_data = 0; fmt_mode = 0; win_load = 0;
      win_x0 = 0; win_x1 = 0; win_y0 = 0; win_y1 = 0; fill_req = 0; fill_color = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // Format conversion in both modes at the default window
      slot_mode = 1; slot_pct = 60;
      push_pix(1'b0, 24'h00F800);
      push_pix(1'b0, 24'h0007E0);
      push_pix(1'b0, 24'h00001F);
      push_pix(1'b1, 24'h123456);
      drain();

      // Window walk with wrap, slots every 4th cycle
      load_win(10, 12, 5, 6, rdy);
      check("win_ready_idle", 32'(rdy), 1);
      slot_mode = 2;
      for (int i = 0; i < 7; i++) push_pix(1'b0, 24'($urandom()));
      drain();

      // Clipping at the right edge; the next pixel lands back on x0
      slot_mode = 1;
      load_win(478, 481, 0, 0, rdy);
      for (int i = 0; i < 4; i++) push_pix(1'b1, 24'($urandom()));
      drain();
      check("clip_two", 32'(clip_cnt_o), 2);
      push_pix(1'b0, 24'($urandom()));
      drain();

      // Back-pressure: full FIFO blocks pixels and window loads
      slot_mode = 0;
      for (int i = 0; i < FD; i++) push_pix(1'b1, 24'($urandom()));
      @(negedge clk);
      check("pix_ready_full", 32'(pix_ready_o), 0);
      check("win_ready_full", 32'(win_ready_o), 0);
      load_win(0, 1, 0, 0, rdy);
      check("win_load_ignored_full", 32'(rdy), 0);
      slot_mode = 1;
      drain();
      load_win(5, 3, 0, 0, rdy);
      check("bad_win_offered", 32'(rdy), 1);
      for (int i = 0; i < 3; i++) push_pix(1'b0, 24'($urandom()));
      drain();

      // Frame fill behind two queued pixels; requests during the fill are ignored
      slot_mode = 0;
      push_pix(1'b0, 24'($urandom()));
      push_pix(1'b1, 24'($urandom()));
      do_fill(24'($urandom()), acc);
      check("fill_accepted", 32'(acc), 1);
      slot_mode = 1; slot_pct = 70;
      repeat (20) @(negedge clk);
      do_fill(24'($urandom()), acc);
      check("fill_req_ignored_busy", 32'(acc), 0);
      load_win(0, 0, 0, 0, rdy);
      check("win_load_ignored_fill", 32'(rdy), 0);
      wait_fill_done();
      @(negedge clk);
      check("pix_ready_after_fill", 32'(pix_ready_o), 1);
      for (int i = 0; i < 3; i++) push_pix(1'b0, 24'($urandom()));
      drain();

      // Randomized windows (some rejected, some off-screen) and pixel bursts
      for (int it = 0; it < 25; it++) begin
         int x0, x1, y0, y1, n;
         x0 = $urandom_range(0, H + 4); x1 = x0 + $urandom_range(0, 5);
         y0 = $urandom_range(0, V + 1); y1 = y0 + $urandom_range(0, 3);
         if ($urandom_range(0, 4) == 0) begin
            x1 = x0; x0 = x0 + 1;
         end
         load_win(x0, x1, y0, y1, rdy);
         check("win_ready_rand", 32'(rdy), 1);
         slot_pct = $urandom_range(20, 100);
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) push_pix(1'($urandom_range(0, 1)), 24'($urandom()));
         drain();
      end

      // Reset mid-stream: queued pixels are discarded, nothing further is written
      load_win(0, H - 1, 0, V - 1, rdy);
      slot_mode = 0;
      for (int i = 0; i < 5; i++) push_pix(1'b0, 24'($urandom()));
      slot_mode = 1; slot_pct = 50;
      repeat (2) @(negedge clk);
      apply_reset();
      w0 = wr_count;
      repeat (20) @(negedge clk);
      check("no_write_after_reset", wr_count - w0, 0);
      push_pix(1'b1, 24'h123456);
      drain();

      // Reset mid-fill
      do_fill(24'hA5C3E1, acc);
      repeat (100) @(negedge clk);
      apply_reset();
      w0 = wr_count;
      repeat (20) @(negedge clk);
      check("no_write_after_fill_reset", wr_count - w0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fb_window_writer.md
Name: fb_window_writer

Overview:
- Parametrised framebuffer write engine for the TFT controller.
- Sits between the SPI command/pixel decoder and the SRAM time-slot sequencer.
- Buffers incoming pixels in a FIFO, walks a programmable CASET/RASET-style window with wrap, converts pixel format to the SRAM word, and clips out-of-screen pixels.
- Performs a hardware fill of the whole frame with a programmable colour. Writes issue only on sequencer-granted slots.

Parameters:
- H_RES, 480, visible width in pixels.
- V_RES, 272, visible height in pixels.
- ROW_OFFSET, 0, rows added to y before address calculation.
- CW, 10, coordinate width (window bounds and cursor).
- ADDR_W, 18, SRAM address width.
- FIFO_DEPTH, 8, pixel FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel offered.
- pix_data  in  24  pixel; mode 0 uses [15:0] RGB565, mode 1 uses [23:0] {R8,G8,B8}.
- pix_ready  out  1  pixel accepted when valid&&ready.
- fmt_mode  in  1  0=RGB565, 1=RGB888; sampled at FIFO push.
- win_load  in  1  load window; accepted only when win_ready=1.
- win_x0, win_x1, win_y0, win_y1  in  CW each  inclusive window bounds.
- win_ready  out  1  FIFO empty, no write pending, not filling.
- win_err  out  1  one-cycle pulse: window rejected.
- fill_req  in  1  start frame fill (pulse).
- fill_color  in  24  SRAM word written by fill; sampled on accept.
- fill_busy  out  1  fill pending or running.
- fill_done  out  1  one-cycle pulse after last fill write.
- wr_slot  in  1  write grant from SRAM sequencer, one cycle.
- sram_we  out  1  write strobe, one cycle.
- sram_waddr  out  ADDR_W  write address.
- sram_wdata  out  24  write word {B8,G8,R8}.
- clip_cnt  out  16  saturating count of clipped pixels.

Behaviour:
Reset:
- pix_ready=1, win_ready=1; all other outputs 0.
- FIFO empty; window x0=0, x1=H_RES-1, y0=0, y1=V_RES-1; cursor (0,0); clip_cnt=0.
- Reset mid-fill or mid-stream aborts everything, with no further sram_we.

Format conversion (at push, stored in FIFO as 24-bit word):
- Mode 0: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
- Mode 1: bytes are swapped to {B,G,R}.

Window load:
- Requires x1≥x0 and y1≥y0, otherwise win_err pulses and the window is unchanged.
- On accept, cursor is set to (x0,y0) the next cycle.
- win_load while win_ready=0 is ignored; no error is raised.

Write path:
- A write is pending when the FIFO is non-empty.
- If wr_slot=1 in cycle N and a write is pending, the engine pops in cycle N. In cycle N+1: sram_we=1, sram_waddr=(y+ROW_OFFSET)*H_RES+x truncated to ADDR_W, sram_wdata=word.
- Cursor advance: x==x1 → x=x0 and y advances (y==y1 → y=y0); otherwise x+1.
- Clip: if x≥H_RES or y≥V_RES, the pop consumes the slot but sram_we stays 0. The cursor still advances and clip_cnt increments, saturating at 16'hFFFF.
- wr_slot with nothing pending produces no write.
- Push and pop in the same cycle are both allowed.

pix_ready:
- pix_ready = !full && !fill_busy.

FSM states: IDLE, DRAIN, FILL, DONE.
- IDLE: fill_req → DRAIN. fill_busy=1 the next cycle, and fill_color is captured.
- DRAIN: remaining FIFO pixels are written normally. When the FIFO is empty and no write is pending → FILL with fill address=0.
- FILL: each wr_slot gives sram_we=1 next cycle, with waddr=fill_addr+ROW_OFFSET*H_RES and wdata=fill_color.
  - fill_addr increments through 0..H_RES*V_RES-1; after the last one → DONE.
- DONE: fill_done=1 for one cycle, fill_busy=0 → IDLE.
- The cursor is untouched by a fill.

Other rules:
- fill_req while fill_busy is ignored.
- win_load while fill_busy is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-stream → all outputs at reset values; after release, one pixel with wr_slot gives waddr=0.
- Window: load x 10..12, y 5..6; push 7 RGB565 pixels with wr_slot every 4th cycle → waddr 2410, 2411, 2412, 2890, 2891, 2892, 2410.
- Format: mode 0 inputs 16'hF800, 16'h07E0, 16'h001F → wdata 24'h0000FF, 24'h00FF00, 24'hFF0000. Mode 1 input 24'h123456 → 24'h563412.
- Fill (H_RES=8, V_RES=4), with 2 pixels queued and fill_req: the 2 pixels are written first, then 32 writes of fill_color at addresses 0..31. fill_done occurs one cycle after the last write, and pix_ready=0 throughout.
- Clip: window x 478..481, y 0..0; push 4 pixels → writes at 478 and 479 only, clip_cnt=2, cursor wraps to x=478.
- Back-pressure/errors: with wr_slot=0, push FIFO_DEPTH pixels → pix_ready=0 and win_ready=0, and win_load is ignored. Then win_load x0=5, x1=3 when idle → win_err pulse, with the window unchanged.
